dreg_rr_arbiter: RTL and testbench



---
 rtl/dreg_arb_pkg.sv | 17 +
 rtl/dreg_rr_arbiter_rr_pick.sv | 40 ++++
 rtl/dreg_rr_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dreg_rr_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dreg_arb_pkg.sv
// dreg_arb_pkg
//   Shared definitions for the round-robin D-register write arbiter:
//   FSM state encoding and the pointer/owner width helper.
package dreg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dreg_rr_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotate-priority encoder. Returns the first set bit of
//   eff_req found scanning upward from ptr, wrapping modulo N_REQ.
//   Ports:
//     eff_req  in   N_REQ  candidate requests
//     ptr      in   PW     highest-priority index
//     winner   out  PW     selected index (0 when none)
//     any      out  1      at least one candidate set
module rr_pick
    import dreg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PW    = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] eff_req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             any
);

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eff_req[wrap_add(ptr, i)]) begin
                winner = wrap_add(ptr, i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dreg_rr_arbiter.sv
// dreg_rr_arbiter
//   Round-robin arbiter and write sequencer owning a shared WIDTH-bit
//   D-register. One write per grant, optional GAP idle cycles after each.
//   Ports:
//     clk, rst_n    clock, asynchronous active-low reset
//     req           per-requester level request
//     data          flattened write data, requester i at [i*WIDTH +: WIDTH]
//     ack           one-cycle grant pulse, one-hot or zero
//     q             shared register contents
//     q_valid       set once any write has completed since reset
//     owner         index of the last writer
//     busy          high in WRITE or GAP state
//   Optional (macro DREG_ARB_STATS_EN):
//     write_cnt     saturating count of completed writes
//     conflict_cnt  saturating count of IDLE/WRITE cycles with >=2 candidates
module dreg_rr_arbiter
    import dreg_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int GAP   = 0,
    localparam int PW   = ptr_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [PW-1:0]          owner,
    output logic                   busy
`ifdef DREG_ARB_STATS_EN
    ,
    output logic [15:0]            write_cnt,
    output logic [15:0]            conflict_cnt
`endif
);

    localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t             state_q, state_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic               q_valid_q, q_valid_d;
    logic [N_REQ-1:0]   ack_q, ack_d;

    logic [N_REQ-1:0]   eff_req;
    logic [PW-1:0]      winner;
    logic               any;
    logic               grant;

    // The requester being acknowledged this cycle is not eligible again yet.
    assign eff_req = req & ~ack_q;

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
        .eff_req (eff_req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any     (any)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            ptr_q     <= '0;
            q_q       <= '0;
            owner_q   <= '0;
            q_valid_q <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            ptr_q     <= ptr_d;
            q_q       <= q_d;
            owner_q   <= owner_d;
            q_valid_q <= q_valid_d;
            ack_q     <= ack_d;
        end
    end

    // Next-state and write datapath
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        ptr_d     = ptr_q;
        q_d       = q_q;
        owner_d   = owner_q;
        q_valid_d = q_valid_q;
        ack_d     = '0;
        grant     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any) grant = 1'b1;
            end
            ST_WRITE: begin
                // Back-to-back grants only without a gap.
                if (GAP == 0 && any) grant = 1'b1;
                else                 state_d = ST_IDLE;
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) state_d = ST_IDLE;
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant) begin
            q_d           = data[int'(winner)*WIDTH +: WIDTH];
            owner_d       = winner;
            q_valid_d     = 1'b1;
            ack_d[winner] = 1'b1;
            ptr_d         = (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
            if (GAP > 0) begin
                state_d   = ST_GAP;
                gap_cnt_d = GAP_M1;
            end else begin
                state_d   = ST_WRITE;
            end
        end
    end

    // Outputs
    always_comb begin
        busy = (state_q == ST_WRITE) || (state_q == ST_GAP);
    end

    assign ack     = ack_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign owner   = owner_q;

`ifdef DREG_ARB_STATS_EN
    logic [15:0]      write_cnt_q, write_cnt_d;
    logic [15:0]      conflict_cnt_q, conflict_cnt_d;
    logic [N_REQ-1:0] rest_req;
    logic [PW-1:0]    unused_winner2;
    logic             multi;

    // A second candidate besides the winner means at least two were set.
    always_comb begin
        rest_req         = eff_req;
        rest_req[winner] = 1'b0;
    end

    rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick2 (
        .eff_req (rest_req),
        .ptr     (ptr_q),
        .winner  (unused_winner2),
        .any     (multi)
    );

    always_comb begin
        write_cnt_d    = write_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (grant && write_cnt_q != 16'hFFFF)
            write_cnt_d = write_cnt_q + 16'd1;
        if (multi && (state_q == ST_IDLE || state_q == ST_WRITE) && conflict_cnt_q != 16'hFFFF)
            conflict_cnt_d = conflict_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            write_cnt_q    <= write_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign write_cnt    = write_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dreg_rr_arbiter.sv
// tb_dreg_rr_arbiter
//   Scoreboard bench: expected grants are queued as stimulus is issued and
//   a negedge monitor pops and compares on every ack pulse. Two instances:
//   dut (GAP=0) and dut_g (GAP=2). Stats ports under DREG_ARB_STATS_EN.
module tb_dreg_rr_arbiter;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] q;
        logic [1:0] owner;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0, req_g = '0;
    logic [31:0] data = '0, data_g = '0;

    logic [3:0]  ack, ack_g;
    logic [7:0]  q, q_g;
    logic        q_valid, q_valid_g;
    logic [1:0]  owner, owner_g;
    logic        busy, busy_g;
`ifdef DREG_ARB_STATS_EN
    logic [15:0] write_cnt, conflict_cnt, write_cnt_g, conflict_cnt_g;
`endif

    exp_t exp_q[$];
    exp_t expg_q[$];
    exp_t mon_e, mon_eg;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dreg_rr_arbiter #(.N_REQ(4), .WIDTH(8), .GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data),
        .ack(ack), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
`ifdef DREG_ARB_STATS_EN
        , .write_cnt(write_cnt), .conflict_cnt(conflict_cnt)
`endif
    );

    dreg_rr_arbiter #(.N_REQ(4), .WIDTH(8), .GAP(2)) dut_g (
        .clk(clk), .rst_n(rst_n), .req(req_g), .data(data_g),
        .ack(ack_g), .q(q_g), .q_valid(q_valid_g), .owner(owner_g), .busy(busy_g)
`ifdef DREG_ARB_STATS_EN
        , .write_cnt(write_cnt_g), .conflict_cnt(conflict_cnt_g)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors: every ack pulse must match the head of its queue.
    always @(negedge clk) begin
        if (ack !== 4'b0000) begin
            if (exp_q.size() == 0) check("dut unexpected ack", 32'(ack), 32'h0);
            else begin
                mon_e = exp_q.pop_front();
                check("dut ack",   32'(ack),   32'(mon_e.ack));
                check("dut q",     32'(q),     32'(mon_e.q));
                check("dut owner", 32'(owner), 32'(mon_e.owner));
            end
        end
        if (ack_g !== 4'b0000) begin
            if (expg_q.size() == 0) check("dut_g unexpected ack", 32'(ack_g), 32'h0);
            else begin
                mon_eg = expg_q.pop_front();
                check("dut_g ack",   32'(ack_g),   32'(mon_eg.ack));
                check("dut_g q",     32'(q_g),     32'(mon_eg.q));
                check("dut_g owner", 32'(owner_g), 32'(mon_eg.owner));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with all requesters active
        rst_n = 1'b0;
        req   = 4'b1111;
        data  = {8'h13, 8'h12, 8'h11, 8'h10};
        step(3);
        check("reset q",       32'(q),       32'h0);
        check("reset ack",     32'(ack),     32'h0);
        check("reset q_valid", 32'(q_valid), 32'h0);
        check("reset busy",    32'(busy),    32'h0);
        check("reset owner",   32'(owner),   32'h0);
        check("reset busy_g",  32'(busy_g),  32'h0);

        // Rotation over 8 back-to-back writes: 10,11,12,13,10,...
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{ack: 4'(1 << (i % 4)), q: 8'(8'h10 + i % 4), owner: 2'(i % 4)});
        rst_n = 1'b1;
        step(1);
        check("first write busy",    32'(busy),    32'h1);
        check("first write q_valid", 32'(q_valid), 32'h1);
        step(7);
`ifdef DREG_ARB_STATS_EN
        check("write_cnt after 8",     32'(write_cnt),                    32'd8);
        check("conflict_cnt >= 7",     32'(conflict_cnt >= 16'd7),        32'h1);
`endif
        req = 4'b0000;
        step(1);
        check("idle after rotation ack", 32'(ack),   32'h0);
        check("idle after rotation busy", 32'(busy), 32'h0);
        check("hold q",     32'(q),     32'h13);
        check("hold owner", 32'(owner), 32'h3);
        step(2);
        check("hold q later", 32'(q), 32'h13);

        // Single requester 2
        req = 4'b0100;
        data[23:16] = 8'hA5;
        exp_q.push_back('{ack: 4'b0100, q: 8'hA5, owner: 2'd2});
        step(1);
        check("single owner", 32'(owner), 32'h2);
        req = 4'b0000;
        step(1);
        check("single ack one cycle", 32'(ack), 32'h0);
        check("single q hold",        32'(q),   32'hA5);

        // GAP=2 spacing on dut_g: writes every 3 cycles
        data_g = {8'h23, 8'h22, 8'h21, 8'h20};
        req_g  = 4'b0011;
        expg_q.push_back('{ack: 4'b0001, q: 8'h20, owner: 2'd0});
        expg_q.push_back('{ack: 4'b0010, q: 8'h21, owner: 2'd1});
        expg_q.push_back('{ack: 4'b0001, q: 8'h20, owner: 2'd0});
        expg_q.push_back('{ack: 4'b0010, q: 8'h21, owner: 2'd1});
        for (int c = 1; c <= 10; c++) begin
            step(1);
            if (c % 3 != 1) check($sformatf("gap no ack c%0d", c), 32'(ack_g), 32'h0);
            check($sformatf("gap busy c%0d", c), 32'(busy_g), 32'((c % 3) != 0));
            if (c == 10) req_g = 4'b0000;
        end
        step(4);

        // Reset in the ack cycle of a grant to requester 3
        req = 4'b1000;
        data[31:24] = 8'h3C;
        step(1);
        check("pre-reset ack3", 32'(ack), 32'h8);
        check("pre-reset q",    32'(q),   32'h3C);
        #1 rst_n = 1'b0;
        #1;
        check("async reset ack",     32'(ack),     32'h0);
        check("async reset q",       32'(q),       32'h0);
        check("async reset q_valid", 32'(q_valid), 32'h0);
        check("async reset owner",   32'(owner),   32'h0);
        check("async reset busy",    32'(busy),    32'h0);
        req = 4'b1001;
        data[7:0] = 8'h55;
        step(1);
        exp_q.push_back('{ack: 4'b0001, q: 8'h55, owner: 2'd0});
        exp_q.push_back('{ack: 4'b1000, q: 8'h3C, owner: 2'd3});
        rst_n = 1'b1;
        step(2);
        req = 4'b0000;
        step(3);

        check("dut queue drained",   32'(exp_q.size()),  32'h0);
        check("dut_g queue drained", 32'(expg_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
